// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: combinational write enables (zero latency) and registered per-stage valid bits.
// Backpressure: mem/fetch/load-use stalls drop upstream write enables; held-PC cycles are counted, saturating.
module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_if_busy,
    input  logic             i_mem_busy,
    input  logic             i_ld_use,
    input  logic             i_br_flush,
    input  logic             i_trap_flush,
    output logic             o_pc_wen,
    output logic             o_ifid_wen,
    output logic             o_idex_wen,
    output logic             o_exmem_wen,
    output logic             o_memwb_wen,
    output logic             o_ifid_vld,
    output logic             o_idex_vld,
    output logic             o_exmem_vld,
    output logic             o_memwb_vld,
    output logic             o_commit,
    output logic [CNT_W-1:0] o_stall_cnt
);

    typedef enum logic [2:0] {
        EV_NONE,
        EV_IF_BUSY,
        EV_LD_USE,
        EV_BR_FLUSH,
        EV_MEM_BUSY,
        EV_TRAP
    } event_e;

    typedef struct packed {
        logic ifid;
        logic idex;
        logic exmem;
        logic memwb;
    } vld_t;

    vld_t             vld_q;
    vld_t             vld_d;
    event_e           ev;
    logic             trap_q;
    logic             br_q;
    logic             ld_q;
    logic [CNT_W-1:0] stall_cnt_q;

    // Events only count when the stage they refer to actually holds an instruction.
    assign trap_q = i_trap_flush & vld_q.memwb;
    assign br_q   = i_br_flush & vld_q.idex;
    assign ld_q   = i_ld_use & vld_q.ifid & vld_q.idex;

    always_comb begin
        ev = EV_NONE;
        if (trap_q) begin
            ev = EV_TRAP;
        end else if (i_mem_busy) begin
            ev = EV_MEM_BUSY;
        end else if (br_q) begin
            ev = EV_BR_FLUSH;
        end else if (ld_q) begin
            ev = EV_LD_USE;
        end else if (i_if_busy) begin
            ev = EV_IF_BUSY;
        end
    end

    always_comb begin
        o_pc_wen    = 1'b1;
        o_ifid_wen  = 1'b1;
        o_idex_wen  = 1'b1;
        o_exmem_wen = 1'b1;
        o_memwb_wen = 1'b1;
        vld_d.ifid  = 1'b1;
        vld_d.idex  = vld_q.ifid;
        vld_d.exmem = vld_q.idex;
        vld_d.memwb = vld_q.exmem;
        case (ev)
            EV_TRAP: begin
                vld_d = '0;
            end
            EV_MEM_BUSY: begin
                o_pc_wen    = 1'b0;
                o_ifid_wen  = 1'b0;
                o_idex_wen  = 1'b0;
                o_exmem_wen = 1'b0;
                vld_d       = vld_q;
                vld_d.memwb = 1'b0;
            end
            EV_BR_FLUSH: begin
                // Redirect PC is written even if the fetch is still busy.
                vld_d.ifid = 1'b0;
                vld_d.idex = 1'b0;
            end
            EV_LD_USE: begin
                o_pc_wen   = 1'b0;
                o_ifid_wen = 1'b0;
                vld_d.ifid = vld_q.ifid;
                vld_d.idex = 1'b0;
            end
            EV_IF_BUSY: begin
                o_pc_wen   = 1'b0;
                vld_d.ifid = 1'b0;
            end
            default: begin
            end
        endcase
        o_commit = vld_q.memwb & ~trap_q;
        if (i_rst_n) begin
            o_pc_wen    = 1'b0;
            o_ifid_wen  = 1'b0;
            o_idex_wen  = 1'b0;
            o_exmem_wen = 1'b0;
            o_memwb_wen = 1'b0;
            o_commit    = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst_n) begin
        if (i_rst_n) begin
            vld_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            if (!o_pc_wen && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign o_ifid_vld  = vld_q.ifid;
    assign o_idex_vld  = vld_q.idex;
    assign o_exmem_vld = vld_q.exmem;
    assign o_memwb_vld = vld_q.memwb;
    assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: an instruction-slot model predicts each cycle, a monitor compares.
`timescale 1ns/1ps
module tb_pipe_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic if_busy = 1'b0, mem_busy = 1'b0, ld_use = 1'b0, br_flush = 1'b0, trap_flush = 1'b0;

    logic pc_wen[2], ifid_wen[2], idex_wen[2], exmem_wen[2], memwb_wen[2];
    logic ifid_vld[2], idex_vld[2], exmem_vld[2], memwb_vld[2], commit[2];
    logic [31:0] cnt32;
    logic [3:0]  cnt4;

    pipe_ctrl u_dut (
        .i_clk(clk), .i_rst_n(rst), .i_if_busy(if_busy), .i_mem_busy(mem_busy),
        .i_ld_use(ld_use), .i_br_flush(br_flush), .i_trap_flush(trap_flush),
        .o_pc_wen(pc_wen[0]), .o_ifid_wen(ifid_wen[0]), .o_idex_wen(idex_wen[0]),
        .o_exmem_wen(exmem_wen[0]), .o_memwb_wen(memwb_wen[0]),
        .o_ifid_vld(ifid_vld[0]), .o_idex_vld(idex_vld[0]), .o_exmem_vld(exmem_vld[0]),
        .o_memwb_vld(memwb_vld[0]), .o_commit(commit[0]), .o_stall_cnt(cnt32)
    );

    pipe_ctrl #(.CNT_W(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst), .i_if_busy(if_busy), .i_mem_busy(mem_busy),
        .i_ld_use(ld_use), .i_br_flush(br_flush), .i_trap_flush(trap_flush),
        .o_pc_wen(pc_wen[1]), .o_ifid_wen(ifid_wen[1]), .o_idex_wen(idex_wen[1]),
        .o_exmem_wen(exmem_wen[1]), .o_memwb_wen(memwb_wen[1]),
        .o_ifid_vld(ifid_vld[1]), .o_idex_vld(idex_vld[1]), .o_exmem_vld(exmem_vld[1]),
        .o_memwb_vld(memwb_vld[1]), .o_commit(commit[1]), .o_stall_cnt(cnt4)
    );

    typedef struct {
        logic [4:0] wen;
        logic       commit;
        logic [3:0] vld;
        int         cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Model: each stage holds an instruction id (0 = bubble); slot[0]=IF/ID .. slot[3]=MEM/WB.
    int slot[4] = '{0, 0, 0, 0};
    int next_id = 1;
    int stalls  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic ib, input logic mb, input logic lu,
                        input logic bf, input logic tf);
        exp_t e;
        int   ns[4];
        logic trap, br, ld;
        @(negedge clk);
        rst = r; if_busy = ib; mem_busy = mb; ld_use = lu; br_flush = bf; trap_flush = tf;
        if (r) begin
            e.wen = 5'b0; e.commit = 1'b0; e.vld = 4'b0; e.cnt = 0;
            slot = '{0, 0, 0, 0};
            stalls = 0;
        end else begin
            e.vld = {slot[0] != 0, slot[1] != 0, slot[2] != 0, slot[3] != 0};
            e.cnt = stalls;
            trap = tf && slot[3] != 0;
            br   = bf && slot[1] != 0;
            ld   = lu && slot[0] != 0 && slot[1] != 0;
            e.commit = (slot[3] != 0) && !trap;
            if (trap) begin
                e.wen = 5'b11111; ns = '{0, 0, 0, 0};
            end else if (mb) begin
                e.wen = 5'b00001; ns = '{slot[0], slot[1], slot[2], 0};
            end else if (br) begin
                e.wen = 5'b11111; ns = '{0, 0, slot[1], slot[2]};
            end else if (ld) begin
                e.wen = 5'b00111; ns = '{slot[0], 0, slot[1], slot[2]};
            end else if (ib) begin
                e.wen = 5'b01111; ns = '{0, slot[0], slot[1], slot[2]};
            end else begin
                e.wen = 5'b11111; ns = '{next_id, slot[0], slot[1], slot[2]};
                next_id++;
            end
            if (!e.wen[4]) stalls++;
            slot = ns;
        end
        sb.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int k = 0; k < 2; k++) begin
                    check($sformatf("wen[%0d]", k),
                          {27'd0, pc_wen[k], ifid_wen[k], idex_wen[k], exmem_wen[k], memwb_wen[k]},
                          {27'd0, e.wen});
                    check($sformatf("commit[%0d]", k), {31'd0, commit[k]}, {31'd0, e.commit});
                    check($sformatf("vld[%0d]", k),
                          {28'd0, ifid_vld[k], idex_vld[k], exmem_vld[k], memwb_vld[k]},
                          {28'd0, e.vld});
                end
                check("stall_cnt32", cnt32, e.cnt);
                check("stall_cnt4", {28'd0, cnt4}, (e.cnt > 15) ? 32'd15 : e.cnt);
            end
        end
    end

    initial begin
        repeat (3) step(1, 0, 0, 0, 0, 0);
        // Fill from reset, then stall on memory for 3 cycles.
        repeat (5) step(0, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 1, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0, 0);
        // Load-use bubble, then branch redirect during a busy fetch.
        step(0, 0, 0, 1, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 0);
        repeat (4) step(0, 0, 0, 0, 0, 0);
        // Trap wins over a simultaneous memory stall.
        step(0, 0, 1, 0, 0, 1);
        repeat (4) step(0, 0, 0, 0, 0, 0);
        // Long fetch stall drives the 4-bit counter into saturation.
        repeat (20) step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // Reset in the middle of a stall.
        step(0, 0, 1, 0, 0, 0);
        repeat (2) step(1, 0, 1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 6) == 0);
        end
        repeat (3) @(negedge clk);
        check("sb_drain", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the stall-cycle counter.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset; asynchronous, active-high (state resets while i_rst_n=1).
REQ-004 SHALL have port i_if_busy  input  1  fetch not complete this cycle.
REQ-005 SHALL have port i_mem_busy  input  1  MEM-stage data access not complete this cycle.
REQ-006 SHALL have port i_ld_use  input  1  ID instruction depends on the load in EX.
REQ-007 SHALL have port i_br_flush  input  1  EX-stage redirect (taken branch or jump).
REQ-008 SHALL have port i_trap_flush  input  1  WB-stage trap or interrupt redirect.
REQ-009 SHALL have ports o_pc_wen, o_ifid_wen, o_idex_wen, o_exmem_wen, o_memwb_wen  output  1 each  write enables for the PC and the four pipeline registers.
REQ-010 SHALL have ports o_ifid_vld, o_idex_vld, o_exmem_vld, o_memwb_vld  output  1 each  registered valid bit per pipeline register.
REQ-011 SHALL have port o_commit  output  1  WB instruction retires this cycle.
REQ-012 SHALL have port o_stall_cnt  output  CNT_W  count of frontend-stall cycles.

Function
REQ-013 SHALL qualify inputs: i_ld_use honoured only when o_ifid_vld=1 and o_idex_vld=1; i_br_flush only when o_idex_vld=1; i_trap_flush only when o_memwb_vld=1.
REQ-014 SHALL resolve qualified events in fixed priority: trap > mem_busy > br_flush > ld_use > if_busy > normal.
REQ-015 SHALL, in normal mode, drive all five wen=1; next vld: ifid<=1, idex<=ifid, exmem<=idex, memwb<=exmem.
REQ-016 SHALL, on trap, drive all wen=1 and clear all four vld on the next edge, regardless of i_mem_busy.
REQ-017 SHALL, on mem_busy, hold o_pc_wen, o_ifid_wen, o_idex_wen, o_exmem_wen at 0 and set o_memwb_wen=1 with memwb<=0 (bubble); other vld unchanged.
REQ-018 SHALL, on br_flush, drive all wen=1; ifid<=0, idex<=0, exmem<=idex, memwb<=exmem.
REQ-019 SHALL, on ld_use, drive o_pc_wen=0 and o_ifid_wen=0, others 1; idex<=0 (bubble), exmem<=idex, memwb<=exmem, ifid unchanged.
REQ-020 SHALL, on if_busy alone, drive o_pc_wen=0, others 1; ifid<=0, remaining stages advance as in REQ-015.
REQ-021 SHALL, when i_br_flush and i_if_busy are both 1, apply br_flush; the redirect PC is written (o_pc_wen=1).
REQ-022 SHALL drive o_commit = o_memwb_vld and not qualified trap.
REQ-023 SHALL increment o_stall_cnt on every edge where o_pc_wen=0, saturating at all-ones (no wrap).
REQ-024 SHALL generate wen outputs combinationally from current inputs and vld state; zero-cycle latency.
REQ-025 SHALL treat X-free inputs only; no input registering.

Reset
REQ-026 SHALL, while i_rst_n=1, force all vld to 0, o_stall_cnt to 0, all wen to 0, o_commit to 0.
REQ-027 SHALL, on the first edge after reset release with no events, drive o_pc_wen=1 and set o_ifid_vld=1.
REQ-028 SHALL abort any stall in progress when reset asserts mid-operation; stall state does not persist across reset.

Verification
REQ-029 SHALL cover reset release, no events, 5 cycles -> vld fill 1000,1100,1110,1111; o_commit=1 from cycle 4; o_stall_cnt=0.
REQ-030 SHALL cover full pipe, i_mem_busy=1 for 3 cycles -> pc/ifid/idex/exmem wen=0, memwb_vld=0 during stall, o_stall_cnt=3, stages resume unchanged.
REQ-031 SHALL cover full pipe, i_ld_use=1 for 1 cycle -> idex_vld=0 next cycle, ifid held, o_stall_cnt +1.
REQ-032 SHALL cover full pipe, i_br_flush=1 with i_if_busy=1 -> o_pc_wen=1, ifid_vld=idex_vld=0, exmem/memwb advance.
REQ-033 SHALL cover i_trap_flush=1 with i_mem_busy=1 and memwb_vld=1 -> all wen=1, o_commit=0, all vld=0 next cycle.
REQ-034 SHALL cover CNT_W=4, i_if_busy=1 for 20 cycles -> o_stall_cnt saturates at 15, no wrap.
